// File: rtl/sr_ctrl_pkg.sv
// Shared opcodes and FSM state encoding for the SR bank arbiter.
package sr_ctrl_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: lowest requester at or above ptr wins, else lowest below ptr.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic             valid
);

    logic             has_hi;
    logic             has_lo;
    logic [PTR_W-1:0] best_hi;
    logic [PTR_W-1:0] best_lo;
    logic [PTR_W-1:0] pick;

    // Scanning downward leaves the lowest matching index in each half.
    always_comb begin
        has_hi  = 1'b0;
        has_lo  = 1'b0;
        best_hi = '0;
        best_lo = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                if (k >= int'(ptr)) begin
                    has_hi  = 1'b1;
                    best_hi = PTR_W'(k);
                end else begin
                    has_lo  = 1'b1;
                    best_lo = PTR_W'(k);
                end
            end
        end
        pick  = has_hi ? best_hi : best_lo;
        valid = has_hi | has_lo;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            win[k] = valid && (int'(pick) == k);
        end
    end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Serialises set/clear requests from several requesters onto one SR bank,
// keeping a shadow of the bank and counting rejected requests.
//   state | meaning
//   IDLE  | waiting for any req; arbitrates and latches the winner
//   ISSUE | one-cycle S or R pulse on the bank
//   ACK   | gnt (and err if rejected) to the winner; q already updated
module sr_bank_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_BITS = 8,
    parameter int IDX_W  = $clog2(N_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [2*N_REQ-1:0]       op,
    input  logic [IDX_W*N_REQ-1:0]   idx,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_BITS-1:0]        s_out,
    output logic [N_BITS-1:0]        r_out,
    output logic [N_BITS-1:0]        q,
    output logic                     busy,
    output logic                     err,
    output logic [7:0]               err_cnt
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_idx_q, win_idx_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_BITS-1:0]  s_q, s_d;
    logic [N_BITS-1:0]  r_q, r_d;
    logic [N_BITS-1:0]  q_q, q_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic [N_REQ-1:0]   pick_win;
    logic               pick_valid;
    logic [PTR_W-1:0]   sel_i;
    logic [1:0]         sel_op;
    logic [IDX_W-1:0]   sel_idx;
    logic               rejected;

    rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        sel_i   = '0;
        sel_op  = OP_NOP;
        sel_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_win[i]) begin
                sel_i   = PTR_W'(i);
                sel_op  = op[2*i +: 2];
                sel_idx = idx[IDX_W*i +: IDX_W];
            end
        end
    end

    // An out-of-range index never matches a cell, so it also yields no pulse.
    assign rejected = (op_q == OP_BAD) || (32'(idx_q) >= N_BITS);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        op_d      = op_q;
        idx_d     = idx_q;
        s_d       = s_q;
        r_d       = r_q;
        q_d       = q_q;
        gnt_d     = gnt_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = ISSUE;
                    win_idx_d = sel_i;
                    op_d      = sel_op;
                    idx_d     = sel_idx;
                    for (int b = 0; b < N_BITS; b++) begin
                        s_d[b] = (sel_op == OP_SET) && (32'(sel_idx) == b);
                        r_d[b] = (sel_op == OP_CLR) && (32'(sel_idx) == b);
                    end
                end
            end
            ISSUE: begin
                state_d = ACK;
                s_d     = '0;
                r_d     = '0;
                q_d     = (q_q | s_q) & ~r_q;
                for (int i = 0; i < N_REQ; i++) begin
                    gnt_d[i] = (32'(win_idx_q) == i);
                end
                err_d = rejected;
                if (rejected && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                err_d   = 1'b0;
                if (32'(win_idx_q) == N_REQ - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win_idx_q + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            op_q      <= OP_NOP;
            idx_q     <= '0;
            s_q       <= '0;
            r_q       <= '0;
            q_q       <= '0;
            gnt_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            s_q       <= s_d;
            r_q       <= r_d;
            q_q       <= q_d;
            gnt_q     <= gnt_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign s_out   = s_q;
    assign r_out   = r_q;
    assign q       = q_q;
    assign busy    = (state_q != IDLE);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Bench for sr_bank_arbiter: vector table, hand-written corner sequences and
// a randomized run against a transaction-level model.
module tb_sr_bank_arbiter;

    localparam int N_REQ  = 4;
    localparam int N_BITS = 8;
    localparam int IDX_W  = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [2*N_REQ-1:0]     op  = '0;
    logic [IDX_W*N_REQ-1:0] idx = '0;
    logic [N_REQ-1:0]       gnt;
    logic [N_BITS-1:0]      s_out, r_out, q;
    logic                   busy, err;
    logic [7:0]             err_cnt;

    int total = 0;
    int bad   = 0;

    sr_bank_arbiter #(.N_REQ(N_REQ), .N_BITS(N_BITS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .gnt(gnt),
        .s_out(s_out), .r_out(r_out), .q(q), .busy(busy), .err(err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [3:0] x);
        req[i]          = 1'b1;
        op[2*i +: 2]    = o;
        idx[4*i +: 4]   = x;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        op  = '0;
        idx = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] rq;
        logic [1:0] o;
        logic [3:0] x;
        logic [7:0] e_s;
        logic [7:0] e_r;
        logic [3:0] e_gnt;
        logic [7:0] e_q;
        logic       e_err;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vt[8];

    // random-phase model state
    int         ptr_m;
    int         cnt_m;
    logic [7:0] q_m;
    bit         pend[N_REQ];
    logic [1:0] pop[N_REQ];
    logic [3:0] pidx[N_REQ];

    initial begin
        vt[0] = '{4'b0100, 2'b01, 4'd5, 8'h20, 8'h00, 4'b0100, 8'h20, 1'b0, 8'd0};
        vt[1] = '{4'b0001, 2'b01, 4'd3, 8'h08, 8'h00, 4'b0001, 8'h28, 1'b0, 8'd0};
        vt[2] = '{4'b1000, 2'b10, 4'd5, 8'h00, 8'h20, 4'b1000, 8'h08, 1'b0, 8'd0};
        vt[3] = '{4'b0010, 2'b11, 4'd1, 8'h00, 8'h00, 4'b0010, 8'h08, 1'b1, 8'd1};
        vt[4] = '{4'b0001, 2'b01, 4'd9, 8'h00, 8'h00, 4'b0001, 8'h08, 1'b1, 8'd2};
        vt[5] = '{4'b0100, 2'b00, 4'd0, 8'h00, 8'h00, 4'b0100, 8'h08, 1'b0, 8'd2};
        vt[6] = '{4'b0010, 2'b10, 4'd3, 8'h00, 8'h08, 4'b0010, 8'h00, 1'b0, 8'd2};
        vt[7] = '{4'b1000, 2'b01, 4'd7, 8'h80, 8'h00, 4'b1000, 8'h80, 1'b0, 8'd2};

        // reset values
        do_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_s", 32'(s_out), 0);
        chk("rst_r", 32'(r_out), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt", 32'(err_cnt), 0);

        // vector table: single requester per entry
        foreach (vt[k]) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (vt[k].rq[i]) set_req(i, vt[k].o, vt[k].x);
            end
            @(negedge clk);
            chk("vec_s", 32'(s_out), 32'(vt[k].e_s));
            chk("vec_r", 32'(r_out), 32'(vt[k].e_r));
            chk("vec_busy", 32'(busy), 1);
            chk("vec_gnt_early", 32'(gnt), 0);
            @(negedge clk);
            chk("vec_gnt", 32'(gnt), 32'(vt[k].e_gnt));
            chk("vec_q", 32'(q), 32'(vt[k].e_q));
            chk("vec_err", 32'(err), 32'(vt[k].e_err));
            chk("vec_cnt", 32'(err_cnt), 32'(vt[k].e_cnt));
            req = '0;
            @(negedge clk);
            chk("vec_idle", 32'(busy), 0);
        end

        // all four hold requests: grants 0,1,2,3,0 every three cycles
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 2'b01, 4'(i));
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("rr_no_gnt", 32'(gnt), 0);
            @(negedge clk);
            chk("rr_gnt", 32'(gnt), 32'(1 << (g % N_REQ)));
            @(negedge clk);
        end
        chk("rr_q", 32'(q), 32'h0F);

        // SET then CLR of the same bit from two requesters
        do_reset();
        set_req(0, 2'b01, 4'd3);
        set_req(1, 2'b10, 4'd3);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("same_overlap", 32'(s_out & r_out), 0);
            if (c == 1) begin
                chk("same_g0", 32'(gnt), 32'b0001);
                chk("same_q1", 32'(q[3]), 1);
                req[0] = 1'b0;
            end
            if (c == 4) begin
                chk("same_g1", 32'(gnt), 32'b0010);
                chk("same_q0", 32'(q[3]), 0);
                req[1] = 1'b0;
            end
        end

        // 300 illegal requests saturate err_cnt
        do_reset();
        set_req(2, 2'b11, 4'd1);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n == 0) chk("bad_no_s", 32'(s_out | r_out), 0);
            @(negedge clk);
            if (n == 0) begin
                chk("bad_err", 32'(err), 1);
                chk("bad_gnt", 32'(gnt), 32'b0100);
                chk("bad_cnt1", 32'(err_cnt), 1);
            end
            if (n == 254) chk("bad_cnt255", 32'(err_cnt), 255);
            @(negedge clk);
        end
        chk("bad_sat", 32'(err_cnt), 255);
        req = '0;

        // reset during ISSUE; ptr must restart at 0
        do_reset();
        set_req(1, 2'b01, 4'd2);
        @(negedge clk);
        @(negedge clk);
        chk("mid_q_pre", 32'(q), 32'h04);
        req = '0;
        @(negedge clk);
        set_req(2, 2'b01, 4'd6);
        @(negedge clk);
        chk("mid_s_issue", 32'(s_out), 32'h40);
        rst = 1'b1;
        #1;
        chk("mid_s", 32'(s_out), 0);
        chk("mid_q", 32'(q), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_gnt", 32'(gnt), 0);
        req = '0;
        @(negedge clk);
        chk("mid_gnt_hold", 32'(gnt), 0);
        rst = 1'b0;
        set_req(0, 2'b01, 4'd1);
        set_req(2, 2'b01, 4'd6);
        @(negedge clk);
        @(negedge clk);
        chk("mid_first", 32'(gnt), 32'b0001);
        chk("mid_first_q", 32'(q), 32'h02);
        req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_second", 32'(gnt), 32'b0100);
        chk("mid_second_q", 32'(q), 32'h42);
        req = '0;
        @(negedge clk);

        // randomized run against the transaction model
        do_reset();
        ptr_m = 0;
        cnt_m = 0;
        q_m   = '0;
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int         w;
            logic [7:0] es, er;
            bit         rej;
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    pop[i]  = 2'($urandom_range(0, 3));
                    if (pop[i] != 2'b00 && $urandom_range(0, 7) == 0)
                        pidx[i] = 4'($urandom_range(8, 15));
                    else
                        pidx[i] = 4'($urandom_range(0, 7));
                    set_req(i, pop[i], pidx[i]);
                end
            end
            w = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (w < 0 && pend[(ptr_m + k) % N_REQ]) w = (ptr_m + k) % N_REQ;
            end
            if (w < 0) begin
                @(negedge clk);
                chk("rnd_idle_busy", 32'(busy), 0);
                continue;
            end
            rej = (pop[w] == 2'b11) || (pidx[w] >= N_BITS);
            es  = (!rej && pop[w] == 2'b01) ? 8'(1 << pidx[w]) : 8'h00;
            er  = (!rej && pop[w] == 2'b10) ? 8'(1 << pidx[w]) : 8'h00;
            @(negedge clk);
            chk("rnd_s", 32'(s_out), 32'(es));
            chk("rnd_r", 32'(r_out), 32'(er));
            q_m = (q_m | es) & ~er;
            if (rej && cnt_m < 255) cnt_m++;
            ptr_m = (w + 1) % N_REQ;
            @(negedge clk);
            chk("rnd_gnt", 32'(gnt), 32'(1 << w));
            chk("rnd_q", 32'(q), 32'(q_m));
            chk("rnd_err", 32'(err), 32'(rej));
            chk("rnd_cnt", 32'(err_cnt), 32'(cnt_m));
            req[w]  = 1'b0;
            pend[w] = 1'b0;
            @(negedge clk);
            chk("rnd_ack_idle", 32'(busy | 1'(gnt != 0)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Round-robin controller that shares one bank of synchronous SR flip-flops between several requesters. Each requester asks to set, clear or leave one bit of the bank. The block serialises these requests and drives one-cycle S/R pulses into the bank, guaranteeing that S=1,R=1 never reaches any cell. It keeps a shadow copy of the bank state, and it rejects illegal requests with an error pulse and a saturating error count.

## Interface

Parameters:
- N_REQ, 4, number of requesters (≥2)
- N_BITS, 8, number of SR cells in the bank (≥2)
- IDX_W, $clog2(N_BITS), width of one bit index

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request, level, held until granted
- op  in  2*N_REQ  per-requester opcode (slice i = op[2i+1:2i]): 00 NOP, 01 SET, 10 CLR, 11 illegal
- idx  in  IDX_W*N_REQ  per-requester target bit index
- gnt  out  N_REQ  one-hot, one-cycle grant/completion pulse
- s_out  out  N_BITS  S inputs to the bank, at most one bit high
- r_out  out  N_BITS  R inputs to the bank, at most one bit high, never overlapping s_out
- q  out  N_BITS  shadow of the bank contents
- busy  out  1  high whenever state ≠ IDLE
- err  out  1  one-cycle pulse, coincident with gnt, for a rejected request
- err_cnt  out  8  saturating count of rejected requests

## Operation

- FSM states: IDLE → ISSUE → ACK → IDLE. There are no other transitions except reset.
- **IDLE:**
  - If any req is high, latch the winner, its op and its idx, then go to ISSUE.
  - Otherwise stay in IDLE.
- **Winner selection:** round-robin.
  - Search starts at the priority pointer ptr and proceeds upward, wrapping modulo N_REQ.
  - After a grant to requester i, ptr = (i+1) mod N_REQ.
  - ptr = 0 after reset.
- **ISSUE:** registered s_out/r_out are valid for exactly this cycle.
  - SET: s_out[idx] = 1.
  - CLR: r_out[idx] = 1.
  - NOP, illegal op (11), or idx ≥ N_BITS: s_out = r_out = 0.
- **ISSUE → ACK edge:** the bank samples S/R. On the same edge q is updated with identical SR semantics (set, clear or hold).
- **ACK:**
  - gnt[winner] = 1.
  - err = 1 if the request was rejected.
  - err_cnt increments on a rejection and saturates at 255.
  - s_out = r_out = 0.
- Requests targeting the same bit are serialised. Order follows round-robin; the last one issued determines the bit's value.
- The arbiter never reads req of the winner during ACK, so a requester that is still holding req is not re-granted before IDLE.

## Timing

- **Latency:** req sampled in IDLE at cycle 0.
  - Cycle 1: s_out/r_out high.
  - Cycle 2: gnt and updated q visible.
  - Cycle 3: IDLE, next arbitration.
- **Throughput:** one operation per 3 cycles.
- **Requester handshake:**
  - req, op and idx must be stable from assertion until the edge that ends the gnt cycle.
  - Drop req, or present the next request, on that edge.
- **Reset values:** gnt = 0, s_out = 0, r_out = 0, q = 0, busy = 0, err = 0, err_cnt = 0, state = IDLE, ptr = 0.
- **Reset mid-operation (rst during ISSUE or ACK):**
  - All outputs return to their reset values immediately.
  - The pending request is dropped without a gnt.
  - The bank must be reset by the same rst so that it matches q = 0.
- **No request:** the block stays in IDLE with all pulses low; q holds.

## Structure

- Package sr_ctrl_pkg holds:
  - opcode constants OP_NOP, OP_SET, OP_CLR, OP_BAD
  - the FSM state enum (IDLE, ISSUE, ACK)
- Sub-module rr_pick (combinational): inputs req and ptr; outputs a one-hot winner and a valid flag. It is parameterised by N_REQ.
- The top level contains the FSM, the latched winner/op/idx, ptr, the S/R output registers, the q shadow and err_cnt.

## Test plan

- Reset, then req[2] = 1 with SET idx = 5:
  - cycle 1: s_out = 8'h20
  - cycle 2: gnt = 4'b0100 and q = 8'h20
  - then r_out stays 0 throughout
- All four requesters hold req continuously, each with SET on its own index: grants arrive in order 0, 1, 2, 3, 0, every 3 cycles.
- Requester 0 sends SET idx 3 while requester 1 sends CLR idx 3: q[3] = 1 after the first grant and 0 after the second. s_out and r_out are never high together.
- Illegal requests:
  - op = 11 gives err with gnt and err_cnt = 1, with no S/R pulse.
  - idx = 9 with N_BITS = 8 gives the same response.
  - 300 illegal requests leave err_cnt = 255.
- Assert rst during ISSUE of a SET:
  - s_out, q, busy and gnt go to 0 immediately.
  - No gnt is issued.
  - After release, the next request is arbitrated starting from ptr = 0.
